// File: rtl/ldpc_pkg.sv
// Shared definitions for the 12-bit, 6-check LDPC code: sizes, H rows,
// codeword bit positions and the encoder FSM states.
package ldpc_pkg;

    localparam int LDPC_N = 12;
    localparam int LDPC_K = 7;
    localparam int LDPC_M = 6;

    // Bit position of vi inside a codeword: v1 sits at the MSB.
    localparam logic [3:0] V1  = 4'd11;
    localparam logic [3:0] V2  = 4'd10;
    localparam logic [3:0] V3  = 4'd9;
    localparam logic [3:0] V4  = 4'd8;
    localparam logic [3:0] V5  = 4'd7;
    localparam logic [3:0] V6  = 4'd6;
    localparam logic [3:0] V7  = 4'd5;
    localparam logic [3:0] V8  = 4'd4;
    localparam logic [3:0] V9  = 4'd3;
    localparam logic [3:0] V10 = 4'd2;
    localparam logic [3:0] V11 = 4'd1;
    localparam logic [3:0] V12 = 4'd0;

    localparam logic [LDPC_N-1:0] H_C1 = 12'h314;
    localparam logic [LDPC_N-1:0] H_C2 = 12'h88A;
    localparam logic [LDPC_N-1:0] H_C3 = 12'h462;
    localparam logic [LDPC_N-1:0] H_C4 = 12'h2A1;
    localparam logic [LDPC_N-1:0] H_C5 = 12'h851;
    localparam logic [LDPC_N-1:0] H_C6 = 12'h50C;

    localparam logic [LDPC_M-1:0][LDPC_N-1:0] H_ROWS = {H_C6, H_C5, H_C4, H_C3, H_C2, H_C1};

    // msg[j] lands at codeword bit MSG_POS[j]; msg is {v4,v7,v8,v9,v10,v11,v12}.
    localparam logic [LDPC_K-1:0][3:0] MSG_POS = {V4, V7, V8, V9, V10, V11, V12};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P3   = 3'd1,
        ST_P5   = 3'd2,
        ST_P1   = 3'd3,
        ST_P6   = 3'd4,
        ST_P2   = 3'd5,
        ST_CHK  = 3'd6,
        ST_OUT  = 3'd7
    } enc_state_e;

    function automatic logic [LDPC_N-1:0] msg_to_cw(input logic [LDPC_K-1:0] m);
        logic [LDPC_N-1:0] c;
        c = '0;
        for (int j = 0; j < LDPC_K; j++) begin
            c[MSG_POS[j]] = m[j];
        end
        return c;
    endfunction

    function automatic logic row_parity(input logic [LDPC_N-1:0] c, input logic [LDPC_N-1:0] mask);
        return ^(c & mask);
    endfunction

endpackage

// File: rtl/ldpc_encoder_parity_step.sv
// Combinational peeling step: for each parity state, the parity bit to
// write and the codeword position it belongs to.
module ldpc_parity_step
    import ldpc_pkg::*;
(
    input  enc_state_e               i_state,
    input  logic [LDPC_N-1:0]        i_cw,
    input  logic                     i_acc,
    output logic                     o_bit,
    output logic [3:0]               o_idx,
    output logic                     o_we
);

    // Select the check row that has exactly one unresolved member this cycle.
    always_comb begin
        o_bit = 1'b0;
        o_idx = 4'd0;
        o_we  = 1'b0;
        case (i_state)
            ST_P3: begin
                o_bit = i_cw[V4] ^ i_cw[V8] ^ i_cw[V10];
                o_idx = V3;
                o_we  = 1'b1;
            end
            ST_P5: begin
                o_bit = i_acc ^ i_cw[V7] ^ i_cw[V12];
                o_idx = V5;
                o_we  = 1'b1;
            end
            ST_P1: begin
                o_bit = i_acc ^ i_cw[V9] ^ i_cw[V11];
                o_idx = V1;
                o_we  = 1'b1;
            end
            ST_P6: begin
                o_bit = i_acc ^ i_cw[V8] ^ i_cw[V12];
                o_idx = V6;
                o_we  = 1'b1;
            end
            ST_P2: begin
                o_bit = i_acc ^ i_cw[V7] ^ i_cw[V11];
                o_idx = V2;
                o_we  = 1'b1;
            end
            default: begin
                o_bit = 1'b0;
                o_idx = 4'd0;
                o_we  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ldpc_encoder.sv
// Systematic serial LDPC encoder: one parity bit per cycle, redundant
// check c6 re-evaluated before the codeword is presented.
module ldpc_encoder
    import ldpc_pkg::*;
#(
    parameter int BPS      = 12,
    parameter int MSG_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [MSG_BITS-1:0]  msg,
    output logic                 cw_valid,
    input  logic                 cw_ready,
    output logic [BPS-1:0]       cw,
    output logic                 cw_err
);

    if (BPS != LDPC_N) begin : g_bad_bps
        $error("ldpc_encoder: BPS must be 12");
    end
    if (MSG_BITS != LDPC_K) begin : g_bad_msg_bits
        $error("ldpc_encoder: MSG_BITS must be 7");
    end

    enc_state_e          r_state;
    enc_state_e          w_next_state;
    logic [LDPC_N-1:0]   r_cw;
    logic                r_acc;
    logic                r_cw_err;
    logic                r_msg_ready;
    logic                r_cw_valid;
    logic                w_accept;
    logic                w_par_bit;
    logic [3:0]          w_par_idx;
    logic                w_par_we;

    assign w_accept = r_msg_ready & msg_valid;

    ldpc_parity_step u_step (
        .i_state (r_state),
        .i_cw    (r_cw),
        .i_acc   (r_acc),
        .o_bit   (w_par_bit),
        .o_idx   (w_par_idx),
        .o_we    (w_par_we)
    );

    // Next-state logic: fixed walk through the parity states, handshake at the ends.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_P3;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_P3:  w_next_state = ST_P5;
            ST_P5:  w_next_state = ST_P1;
            ST_P1:  w_next_state = ST_P6;
            ST_P6:  w_next_state = ST_P2;
            ST_P2:  w_next_state = ST_CHK;
            ST_CHK: w_next_state = ST_OUT;
            ST_OUT: begin
                if (cw_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OUT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State and handshake flags; flags are registered copies of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_msg_ready <= 1'b1;
            r_cw_valid  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_msg_ready <= (w_next_state == ST_IDLE);
            r_cw_valid  <= (w_next_state == ST_OUT);
        end
    end

    // Codeword, accumulator and self-check registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw     <= 12'h000;
            r_acc    <= 1'b0;
            r_cw_err <= 1'b0;
        end else if (w_accept) begin
            r_cw     <= msg_to_cw(msg);
            r_acc    <= 1'b0;
            r_cw_err <= 1'b0;
        end else if (w_par_we) begin
            r_cw[w_par_idx] <= w_par_bit;
            r_acc           <= w_par_bit;
        end else if (r_state == ST_CHK) begin
            r_cw_err <= row_parity(r_cw, H_ROWS[5]);
        end else begin
            r_cw     <= r_cw;
            r_acc    <= r_acc;
            r_cw_err <= r_cw_err;
        end
    end

    assign msg_ready = r_msg_ready;
    assign cw_valid  = r_cw_valid;
    assign cw        = r_cw;
    assign cw_err    = r_cw_err;

endmodule

// File: tb/tb_ldpc_encoder.sv
// Self-checking bench for ldpc_encoder: directed vectors, backpressure,
// mid-encode reset and randomized messages against a brute-force parity solver.
module tb_ldpc_encoder;

    logic        clk;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [6:0]  msg;
    logic        cw_valid;
    logic        cw_ready;
    logic [11:0] cw;
    logic        cw_err;

    int n_checks;
    int n_fail;

    // Code description by variable number (vi), independent of the RTL tables.
    int unsigned msg_v [7]    = '{4, 7, 8, 9, 10, 11, 12};
    int unsigned par_v [5]    = '{3, 5, 1, 6, 2};
    int unsigned rows  [6][4] = '{'{3, 4, 8, 10}, '{1, 5, 9, 11}, '{2, 6, 7, 11},
                                  '{3, 5, 7, 12}, '{1, 6, 8, 12}, '{2, 4, 9, 10}};

    ldpc_encoder #(.BPS(12), .MSG_BITS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg       (msg),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw        (cw),
        .cw_err    (cw_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rows_ok(input logic [11:0] c);
        for (int r = 0; r < 6; r++) begin
            logic x;
            x = 1'b0;
            for (int k = 0; k < 4; k++) x ^= c[12 - rows[r][k]];
            if (x) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Place the message, then try all 32 parity assignments and keep the one satisfying H.
    function automatic logic [11:0] model_cw(input logic [6:0] m);
        logic [11:0] base;
        logic [11:0] c;
        base = '0;
        for (int j = 0; j < 7; j++) base[12 - msg_v[j]] = m[6 - j];
        for (int p = 0; p < 32; p++) begin
            c = base;
            for (int k = 0; k < 5; k++) c[12 - par_v[k]] = p[k];
            if (rows_ok(c)) return c;
        end
        return 12'h000;
    endfunction

    function automatic logic [6:0] msg_of(input logic [11:0] c);
        logic [6:0] m;
        for (int j = 0; j < 7; j++) m[6 - j] = c[12 - msg_v[j]];
        return m;
    endfunction

    task automatic send(input logic [6:0] m);
        int n;
        n = 0;
        while (!msg_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", msg_ready, 1);
        msg_valid = 1'b1;
        msg       = m;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        msg       = 7'($urandom);
    endtask

    // Count rising edges from the accepting one until cw_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!cw_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("valid_timeout", cw_valid, 1);
    endtask

    task automatic encode_directed(input string tag, input logic [6:0] m, input logic [11:0] exp);
        int lat;
        cw_ready = 1'b1;
        send(m);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 7);
        check({tag, "_cw"}, cw, exp);
        check({tag, "_err"}, cw_err, 0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, msg_ready, 1);
        check({tag, "_valid_drop"}, cw_valid, 0);
    endtask

    initial begin
        int lat;
        int hold;
        logic [6:0]  m;
        logic [11:0] exp;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg       = 7'h00;
        cw_ready  = 1'b0;
        #12;
        check("rst_msg_ready", msg_ready, 1);
        check("rst_cw_valid", cw_valid, 0);
        check("rst_cw", cw, 12'h000);
        check("rst_cw_err", cw_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        encode_directed("zero", 7'h00, 12'h000);
        encode_directed("v4", 7'h40, 12'hFC0);
        encode_directed("v12", 7'h01, 12'h881);
        encode_directed("ones", 7'h7F, 12'hFFF);

        // Backpressure: codeword must hold and new offers must be ignored.
        cw_ready = 1'b0;
        send(7'h01);
        wait_valid(lat);
        check("bp_cw_first", cw, 12'h881);
        for (int k = 0; k < 5; k++) begin
            msg_valid = 1'b1;
            msg       = 7'h7F;
            @(posedge clk); #1;
            check("bp_valid", cw_valid, 1);
            check("bp_cw", cw, 12'h881);
            check("bp_err", cw_err, 0);
            check("bp_msg_ready", msg_ready, 0);
        end
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", msg_ready, 1);
        check("bp_release_valid", cw_valid, 0);
        repeat (9) @(posedge clk);
        #1;
        check("bp_no_capture", cw_valid, 0);

        // Reset while in P6.
        send(7'h7F);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", cw_valid, 0);
        check("midrst_cw", cw, 12'h000);
        check("midrst_ready", msg_ready, 1);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        encode_directed("after_rst", 7'h40, 12'hFC0);

        for (int i = 0; i < 500; i++) begin
            m        = 7'($urandom);
            exp      = model_cw(m);
            cw_ready = 1'($urandom_range(0, 1));
            send(m);
            wait_valid(lat);
            check("rnd_latency", lat, 7);
            check("rnd_cw", cw, exp);
            check("rnd_rows", rows_ok(cw), 1);
            check("rnd_msg_bits", msg_of(cw), m);
            check("rnd_err", cw_err, 0);
            hold = 0;
            while (!cw_ready) begin
                @(posedge clk); #1;
                check("rnd_hold_valid", cw_valid, 1);
                check("rnd_hold_cw", cw, exp);
                hold++;
                cw_ready = (hold >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            check("rnd_valid_drop", cw_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
